// File: rtl/keymux_lock_seq.sv
// keymux_lock_seq: NUM_MUX keyed 4:1 selectors with a serially loaded key.
// Ports:
//   clk, rst_n (sync, active low)
//   key_start, key_valid, key_bit, key_ready : serial key load (LSB first)
//   in_valid, cand_bus                       : candidate nets in
//   out_valid, out_bus                       : registered selector outputs
//   zeroize                                  : only with KEYMUX_ZEROIZE_EN
// Optional macro: KEYMUX_ZEROIZE_EN adds the zeroize input.
// Data is only passed through once the complete key is held (ACTIVE).
module keymux_lock_seq #(
    parameter int NUM_MUX = 3,
    parameter int DATA_W  = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
`ifdef KEYMUX_ZEROIZE_EN
    input  logic                        zeroize,
`endif
    input  logic                        key_start,
    input  logic                        key_valid,
    input  logic                        key_bit,
    output logic                        key_ready,
    input  logic                        in_valid,
    input  logic [NUM_MUX*4*DATA_W-1:0] cand_bus,
    output logic                        out_valid,
    output logic [NUM_MUX*DATA_W-1:0]   out_bus
);

    localparam int KEY_W = 2 * NUM_MUX;
    localparam int CNT_W = $clog2(KEY_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ACTIVE
    } state_e;

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [KEY_W-1:0]            key_q, key_d;
    logic                        key_ready_q, key_ready_d;
    logic                        out_valid_q, out_valid_d;
    logic [NUM_MUX*DATA_W-1:0]   out_bus_q, out_bus_d;
    logic [NUM_MUX*DATA_W-1:0]   mux_bus;
    logic                        zap;

`ifdef KEYMUX_ZEROIZE_EN
    assign zap = zeroize;
`else
    assign zap = 1'b0;
`endif

    // Selector m uses key bits [2m+1:2m] to pick candidate c of its group.
    always_comb begin
        mux_bus = '0;
        for (int m = 0; m < NUM_MUX; m++) begin
            logic [1:0] sel;
            sel = key_q[2*m +: 2];
            mux_bus[m*DATA_W +: DATA_W] =
                cand_bus[(4*m + int'(sel))*DATA_W +: DATA_W];
        end
    end

    // Key-load FSM next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;

        unique case (state_q)
            ST_IDLE: begin
                if (key_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    key_d   = '0;
                end
            end
            ST_LOAD: begin
                // A restart wins over a same-cycle key bit, which is dropped.
                if (key_start) begin
                    cnt_d = '0;
                    key_d = '0;
                end else if (key_valid) begin
                    key_d[cnt_q] = key_bit;
                    cnt_d        = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(KEY_W - 1)) begin
                        state_d = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (key_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    key_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                key_d   = '0;
            end
        endcase

        if (zap) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            key_d   = '0;
        end
    end

    // Outputs are registered. Data only flows when the FSM is ACTIVE now and
    // stays ACTIVE, so a reload or zeroize request suppresses that cycle.
    always_comb begin
        key_ready_d = (state_d == ST_ACTIVE);
        out_valid_d = 1'b0;
        out_bus_d   = '0;
        if ((state_q == ST_ACTIVE) && (state_d == ST_ACTIVE)) begin
            out_valid_d = in_valid;
            out_bus_d   = in_valid ? mux_bus : out_bus_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            key_q       <= '0;
            key_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_bus_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            key_ready_q <= key_ready_d;
            out_valid_q <= out_valid_d;
            out_bus_q   <= out_bus_d;
        end
    end

    assign key_ready = key_ready_q;
    assign out_valid = out_valid_q;
    assign out_bus   = out_bus_q;

endmodule

// File: tb/tb_keymux_lock_seq.sv
// tb_keymux_lock_seq: directed bench for keymux_lock_seq (NUM_MUX=3, DATA_W=1).
// Optional macro: KEYMUX_ZEROIZE_EN enables the zeroize scenario.
module tb_keymux_lock_seq;

    logic        clk;
    logic        rst_n;
    logic        key_start;
    logic        key_valid;
    logic        key_bit;
    logic        key_ready;
    logic        in_valid;
    logic [11:0] cand_bus;
    logic        out_valid;
    logic [2:0]  out_bus;
`ifdef KEYMUX_ZEROIZE_EN
    logic        zeroize;
`endif

    int checks;
    int errors;

    keymux_lock_seq #(.NUM_MUX(3), .DATA_W(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef KEYMUX_ZEROIZE_EN
        .zeroize   (zeroize),
`endif
        .key_start (key_start),
        .key_valid (key_valid),
        .key_bit   (key_bit),
        .key_ready (key_ready),
        .in_valid  (in_valid),
        .cand_bus  (cand_bus),
        .out_valid (out_valid),
        .out_bus   (out_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        key_start = 1'b0;
        key_valid = 1'b0;
        key_bit   = 1'b0;
        in_valid  = 1'b0;
        cand_bus  = '0;
`ifdef KEYMUX_ZEROIZE_EN
        zeroize   = 1'b0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // key_start pulse followed by six key bits, LSB first.
    task automatic load_key(input logic [5:0] k);
        key_start = 1'b1;
        step();
        key_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            key_valid = 1'b1;
            key_bit   = k[i];
            step();
        end
        key_valid = 1'b0;
        key_bit   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        key_start = 1'($urandom);
        key_valid = 1'($urandom);
        key_bit   = 1'($urandom);
        in_valid  = 1'($urandom);
        cand_bus  = 12'($urandom);
`ifdef KEYMUX_ZEROIZE_EN
        zeroize   = 1'b0;
`endif
        step();
        step();
        checks++;
        if (key_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_key_ready got %b want 0", key_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (out_bus !== 3'b000) begin
            errors++;
            $display("FAIL rst_out_bus got %b want 000", out_bus);
        end
        rst_n     = 1'b1;
        key_start = 1'b0;
        key_valid = 1'b1;
        key_bit   = 1'b1;
        in_valid  = 1'b1;
        cand_bus  = 12'hfff;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (key_ready !== 1'b0 || out_valid !== 1'b0 || out_bus !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_rst got %b/%b/%b want 0/0/000",
                     key_ready, out_valid, out_bus);
        end
        idle_inputs();
    endtask

    task automatic test_load_select();
        logic [5:0] k;
        do_reset();
        k = 6'b110110;
        key_start = 1'b1;
        step();
        key_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            key_valid = 1'b1;
            key_bit   = k[i];
            step();
            if (i == 4) begin
                checks++;
                if (key_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_early got %b want 0", key_ready);
                end
            end
        end
        key_valid = 1'b0;
        checks++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_6 got %b want 1", key_ready);
        end
        // sel0=c2, sel1=c1, sel2=c3
        in_valid = 1'b1;
        cand_bus = 12'b1000_0100_0010;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_bus !== 3'b100) begin
            errors++;
            $display("FAIL sel_vec1 got %b/%b want 1/100", out_valid, out_bus);
        end
        cand_bus = 12'b1000_0010_0100;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_bus !== 3'b111) begin
            errors++;
            $display("FAIL sel_b2b got %b/%b want 1/111", out_valid, out_bus);
        end
        in_valid = 1'b0;
        cand_bus = 12'h000;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_bus !== 3'b111) begin
            errors++;
            $display("FAIL hold got %b/%b want 0/111", out_valid, out_bus);
        end
        // Extra key bits in ACTIVE must not disturb the key.
        key_valid = 1'b1;
        key_bit   = 1'b0;
        step();
        step();
        key_valid = 1'b0;
        in_valid  = 1'b1;
        cand_bus  = 12'b0111_1101_1011;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_bus !== 3'b000 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL extra_bits got %b/%b/%b want 1/1/000",
                     key_ready, out_valid, out_bus);
        end
        idle_inputs();
    endtask

    task automatic test_locked();
        do_reset();
        in_valid = 1'b1;
        cand_bus = 12'hfff;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_bus !== 3'b000) begin
            errors++;
            $display("FAIL locked_idle got %b/%b want 0/000", out_valid, out_bus);
        end
        key_start = 1'b1;
        step();
        key_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            key_valid = 1'b1;
            key_bit   = 1'b1;
            step();
            checks++;
            if (out_valid !== 1'b0 || out_bus !== 3'b000 || key_ready !== 1'b0) begin
                errors++;
                $display("FAIL locked_load%0d got %b/%b/%b want 0/0/000",
                         i, key_ready, out_valid, out_bus);
            end
        end
        key_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (out_valid !== 1'b0 || out_bus !== 3'b000 || key_ready !== 1'b0) begin
            errors++;
            $display("FAIL locked_stall got %b/%b/%b want 0/0/000",
                     key_ready, out_valid, out_bus);
        end
        idle_inputs();
    endtask

    task automatic test_restart();
        do_reset();
        key_start = 1'b1;
        step();
        key_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            key_valid = 1'b1;
            key_bit   = 1'b0;
            step();
        end
        key_start = 1'b1;
        key_valid = 1'b1;
        key_bit   = 1'b1;
        step();
        key_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            key_valid = 1'b1;
            key_bit   = 1'b1;
            step();
        end
        checks++;
        if (key_ready !== 1'b0) begin
            errors++;
            $display("FAIL restart_5bits got %b want 0", key_ready);
        end
        step();
        key_valid = 1'b0;
        checks++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL restart_6bits got %b want 1", key_ready);
        end
        in_valid = 1'b1;
        cand_bus = 12'b1000_1000_1000;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_bus !== 3'b111) begin
            errors++;
            $display("FAIL restart_c3 got %b/%b want 1/111", out_valid, out_bus);
        end
        cand_bus = 12'b0111_0111_0111;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_bus !== 3'b000) begin
            errors++;
            $display("FAIL restart_not_c3 got %b/%b want 1/000", out_valid, out_bus);
        end
        idle_inputs();
    endtask

    task automatic test_reload();
        do_reset();
        load_key(6'b101010);
        key_start = 1'b1;
        in_valid  = 1'b1;
        cand_bus  = 12'hfff;
        step();
        key_start = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_bus !== 3'b000 || key_ready !== 1'b0) begin
            errors++;
            $display("FAIL reload got %b/%b/%b want 0/0/000",
                     key_ready, out_valid, out_bus);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            key_valid = 1'b1;
            key_bit   = 1'b1;
            step();
        end
        key_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        // In IDLE, key bits without key_start must not complete a key.
        for (int i = 0; i < 6; i++) begin
            key_valid = 1'b1;
            key_bit   = 1'b1;
            in_valid  = 1'b1;
            step();
        end
        key_valid = 1'b0;
        checks++;
        if (key_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reload_rst_idle got %b/%b want 0/0", key_ready, out_valid);
        end
        in_valid = 1'b0;
        load_key(6'b000000);
        in_valid = 1'b1;
        cand_bus = 12'b0001_1110_0001;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_bus !== 3'b101) begin
            errors++;
            $display("FAIL reload_zero_key got %b/%b want 1/101", out_valid, out_bus);
        end
        idle_inputs();
    endtask

`ifdef KEYMUX_ZEROIZE_EN
    task automatic test_zeroize();
        do_reset();
        load_key(6'b111111);
        in_valid = 1'b1;
        cand_bus = 12'hfff;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_bus !== 3'b111) begin
            errors++;
            $display("FAIL zero_pre got %b/%b want 1/111", out_valid, out_bus);
        end
        zeroize   = 1'b1;
        key_start = 1'b1;
        step();
        zeroize   = 1'b0;
        key_start = 1'b0;
        checks++;
        if (key_ready !== 1'b0 || out_valid !== 1'b0 || out_bus !== 3'b000) begin
            errors++;
            $display("FAIL zeroize got %b/%b/%b want 0/0/000",
                     key_ready, out_valid, out_bus);
        end
        // Must be IDLE (not LOAD): six bits alone should not unlock.
        for (int i = 0; i < 6; i++) begin
            key_valid = 1'b1;
            key_bit   = 1'b1;
            step();
        end
        checks++;
        if (key_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle got %b/%b want 0/0", key_ready, out_valid);
        end
        idle_inputs();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_load_select();
        test_locked();
        test_restart();
        test_reload();
`ifdef KEYMUX_ZEROIZE_EN
        test_zeroize();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
